// File: rtl/wire_raster_engine_if.sv
// Triangle-in / pixel-out bundle for the wireframe raster engine.
// slave: the engine; master: the projection source and SRAM-writer sink.
interface wire_raster_engine_if #(
  parameter int COORD_W = 10,
  parameter int CLIP_W  = 8,
  parameter int ADDR_W  = 15
);
  // Both channels use valid/ready: a beat moves on a cycle where valid && ready
  // are both high, and the offering side holds valid and its payload stable
  // until that cycle.
  logic                      tri_valid;
  logic                      tri_ready;
  logic signed [COORD_W-1:0] x0, y0, x1, y1, x2, y2;
  logic [1:0]                mode;
  logic                      erase;
  logic                      pix_valid;
  logic                      pix_ready;
  logic [ADDR_W-1:0]         pix_addr;
  logic                      pix_data;
  logic                      busy;
  logic                      done;
  logic [CLIP_W-1:0]         clip_count;
  logic [1:0]                dbg_state;

  modport slave (
    input  tri_valid, x0, y0, x1, y1, x2, y2, mode, erase, pix_ready,
    output tri_ready, pix_valid, pix_addr, pix_data, busy, done, clip_count, dbg_state
  );

  modport master (
    output tri_valid, x0, y0, x1, y1, x2, y2, mode, erase, pix_ready,
    input  tri_ready, pix_valid, pix_addr, pix_data, busy, done, clip_count, dbg_state
  );
endinterface

// File: rtl/wire_raster_engine.sv
// Wireframe triangle rasterizer: walks each edge with an all-octant Bresenham
// stepper, emits on-screen pixels as (addr, data) beats, counts clipped ones.
module wire_raster_engine #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int COORD_W  = 10,
  parameter int CLIP_W   = 8,
  parameter int ADDR_W   = $clog2(SCREEN_W * SCREEN_H)
) (
  input  logic clk,
  input  logic n_rst,
  wire_raster_engine_if.slave bus
);

  localparam int XW = COORD_W + 1;
  localparam int DW = COORD_W + 2;
  localparam int EW = COORD_W + 3;

  typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;
  state_t state, state_next;

  logic signed [COORD_W-1:0] vx [3];
  logic signed [COORD_W-1:0] vy [3];
  logic [1:0]                mode_r;
  logic                      erase_r;
  logic [1:0]                edge_idx;
  logic signed [XW-1:0]      x, y, qx, qy;
  logic signed [DW-1:0]      dx, dy, err;
  logic                      sx_neg, sy_neg;
  logic [CLIP_W-1:0]         clip_cnt;

  // Edge endpoint selection from mode and edge index
  logic [1:0] p_idx, q_idx;
  logic       last_edge;

  always_comb begin
    p_idx     = edge_idx;
    q_idx     = edge_idx;
    last_edge = (edge_idx == 2'd2);
    case (mode_r)
      2'd1: begin
        p_idx     = 2'd0;
        q_idx     = 2'd1;
        last_edge = 1'b1;
      end
      2'd2: ;
      default: q_idx = (edge_idx == 2'd2) ? 2'd0 : edge_idx + 2'd1;
    endcase
  end

  logic signed [XW-1:0] px, py, ql_x, ql_y;
  logic signed [DW-1:0] ddx, ddy, adx, ady;

  always_comb begin
    px   = XW'(vx[p_idx]);
    py   = XW'(vy[p_idx]);
    ql_x = XW'(vx[q_idx]);
    ql_y = XW'(vy[q_idx]);
    ddx  = DW'(ql_x) - DW'(px);
    ddy  = DW'(ql_y) - DW'(py);
    adx  = (ddx < 0) ? -ddx : ddx;
    ady  = (ddy < 0) ? -ddy : ddy;
  end

  logic                 in_bounds, at_end, advance, step_x, step_y;
  logic signed [EW-1:0] e2;
  logic signed [DW-1:0] err_next;

  always_comb begin
    in_bounds = (x >= 0) && (x < XW'(SCREEN_W)) && (y >= 0) && (y < XW'(SCREEN_H));
    at_end    = (x == qx) && (y == qy);
    advance   = (state == DRAW) && (!in_bounds || bus.pix_ready);
    e2        = {err, 1'b0};
    step_x    = (e2 >= EW'(dy));
    step_y    = (e2 <= EW'(dx));
    err_next  = err;
    if (step_x) err_next = err_next + dy;
    if (step_y) err_next = err_next + dx;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.tri_valid) state_next = LOAD;
      LOAD: state_next = DRAW;
      DRAW: if (advance && at_end) state_next = last_edge ? DONE : LOAD;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 3; i++) begin
        vx[i] <= '0;
        vy[i] <= '0;
      end
      mode_r   <= '0;
      erase_r  <= 1'b0;
      edge_idx <= '0;
      x        <= '0;
      y        <= '0;
      qx       <= '0;
      qy       <= '0;
      dx       <= '0;
      dy       <= '0;
      err      <= '0;
      sx_neg   <= 1'b0;
      sy_neg   <= 1'b0;
      clip_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (bus.tri_valid) begin
          vx[0]    <= bus.x0;
          vy[0]    <= bus.y0;
          vx[1]    <= bus.x1;
          vy[1]    <= bus.y1;
          vx[2]    <= bus.x2;
          vy[2]    <= bus.y2;
          mode_r   <= (bus.mode == 2'd3) ? 2'd0 : bus.mode;
          erase_r  <= bus.erase;
          edge_idx <= '0;
          clip_cnt <= '0;
        end
        LOAD: begin
          x      <= px;
          y      <= py;
          qx     <= ql_x;
          qy     <= ql_y;
          dx     <= adx;
          dy     <= -ady;
          err    <= adx - ady;
          sx_neg <= (ddx < 0);
          sy_neg <= (ddy < 0);
        end
        DRAW: begin
          // Off-screen pixels are counted and stepped past without a beat
          if (!in_bounds && (clip_cnt != '1)) clip_cnt <= clip_cnt + 1'b1;
          if (advance) begin
            if (at_end) begin
              if (!last_edge) edge_idx <= edge_idx + 2'd1;
            end else begin
              if (step_x) x <= sx_neg ? x - XW'(1) : x + XW'(1);
              if (step_y) y <= sy_neg ? y - XW'(1) : y + XW'(1);
              err <= err_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

  logic pix_valid_int;
  assign pix_valid_int  = (state == DRAW) && in_bounds;

  assign bus.tri_ready  = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.pix_valid  = pix_valid_int;
  assign bus.pix_data   = pix_valid_int & ~erase_r;
  assign bus.pix_addr   = pix_valid_int
                        ? ADDR_W'($unsigned(y)) * ADDR_W'(SCREEN_W) + ADDR_W'($unsigned(x))
                        : '0;
  assign bus.clip_count = clip_cnt;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_wire_raster_engine.sv
// Bench for wire_raster_engine: expected beats (cycle offset, address, data)
// are queued before each triangle and popped by a negedge monitor.
module tb_wire_raster_engine;

  localparam int COORD_W = 10;
  localparam int CLIP_W  = 8;
  localparam int ADDR_W  = 15;
  localparam int W       = 24;

  logic clk = 1'b0;
  logic n_rst;

  wire_raster_engine_if #(.COORD_W(COORD_W), .CLIP_W(CLIP_W), .ADDR_W(ADDR_W)) bus ();

  wire_raster_engine #(
    .SCREEN_W(160), .SCREEN_H(120), .COORD_W(COORD_W), .CLIP_W(CLIP_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus.slave)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int exp_done_off = 0;
  logic done_seen = 1'b0;
  logic [W-1:0] exp_q[$];

  logic              prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void push(input int off, input int addr, input logic d);
    exp_q.push_back({8'(off), 15'(addr), d});
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!n_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.tri_valid && bus.tri_ready) accept_cyc = cyc;
      if (prev_stall) begin
        check("hold_valid", 32'(bus.pix_valid), 1);
        check("hold_addr", 32'(bus.pix_addr), 32'(prev_addr));
      end
      if (bus.pix_valid && bus.pix_ready) begin
        check("beat_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("beat_cycle", 32'(cyc - accept_cyc), 32'(e[23:16]));
          check("beat_addr", 32'(bus.pix_addr), 32'(e[15:1]));
          check("beat_data", 32'(bus.pix_data), 32'(e[0]));
        end
      end
      if (bus.done) begin
        check("done_cycle", 32'(cyc - accept_cyc), 32'(exp_done_off));
        done_seen = 1'b1;
      end
      prev_stall = bus.pix_valid && !bus.pix_ready;
      prev_addr  = bus.pix_addr;
    end
  end

  // driver tasks
  task automatic send(input int ax0, input int ay0, input int ax1, input int ay1,
                      input int ax2, input int ay2, input logic [1:0] m, input logic er);
    @(posedge clk); #1;
    bus.x0 = COORD_W'(ax0);
    bus.y0 = COORD_W'(ay0);
    bus.x1 = COORD_W'(ax1);
    bus.y1 = COORD_W'(ay1);
    bus.x2 = COORD_W'(ax2);
    bus.y2 = COORD_W'(ay2);
    bus.mode  = m;
    bus.erase = er;
    done_seen = 1'b0;
    bus.tri_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.tri_ready) break;
    end
    @(posedge clk); #1;
    bus.tri_valid = 1'b0;
    bus.mode = 2'd3;
    bus.x0 = '0;
  endtask

  task automatic wait_done(input string tag, input int exp_clip);
    for (int i = 0; i < 200 && !done_seen; i++) @(posedge clk);
    #1;
    check({tag, "_done_seen"}, 32'(done_seen), 1);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 0);
    check({tag, "_clip"}, 32'(bus.clip_count), 32'(exp_clip));
    check({tag, "_ready_after"}, 32'(bus.tri_ready), 1);
    check({tag, "_busy_after"}, 32'(bus.busy), 0);
  endtask

  task automatic line_test(input string tag);
    for (int i = 0; i < 4; i++) push(2 + i, 482 + i, 1'b1);
    exp_done_off = 6;
    send(2, 3, 5, 3, 0, 0, 2'd1, 1'b0);
    wait_done(tag, 0);
  endtask

  task automatic push_triangle();
    push(2, 0, 1'b1);   push(3, 1, 1'b1);   push(4, 2, 1'b1);
    push(6, 2, 1'b1);   push(7, 161, 1'b1); push(8, 320, 1'b1);
    push(10, 320, 1'b1); push(11, 160, 1'b1); push(12, 0, 1'b1);
    exp_done_off = 13;
  endtask

  initial begin
    n_rst = 1'b0;
    bus.tri_valid = 1'b0;
    bus.pix_ready = 1'b1;
    bus.mode = 2'd0;
    bus.erase = 1'b0;
    bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0; bus.x2 = '0; bus.y2 = '0;
    #12;
    check("rst_tri_ready", 32'(bus.tri_ready), 1);
    check("rst_pix_valid", 32'(bus.pix_valid), 0);
    check("rst_pix_addr", 32'(bus.pix_addr), 0);
    check("rst_pix_data", 32'(bus.pix_data), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_clip", 32'(bus.clip_count), 0);
    @(negedge clk);
    n_rst = 1'b1;

    line_test("line");

    push_triangle();
    send(0, 0, 2, 0, 0, 2, 2'd0, 1'b0);
    wait_done("tri", 0);

    // backpressure: second beat stalls for three cycles
    push(2, 482, 1'b1); push(6, 483, 1'b1); push(7, 484, 1'b1); push(8, 485, 1'b1);
    exp_done_off = 9;
    send(2, 3, 5, 3, 0, 0, 2'd1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.pix_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.pix_ready = 1'b1;
    wait_done("bp", 0);

    push(4, 800, 1'b1); push(5, 801, 1'b1);
    exp_done_off = 6;
    send(-2, 5, 1, 5, 0, 0, 2'd1, 1'b0);
    wait_done("clip", 2);

    push(2, 19199, 1'b0); push(4, 0, 1'b0);
    exp_done_off = 7;
    send(159, 119, 0, 0, 200, 10, 2'd2, 1'b1);
    wait_done("points", 1);

    // mode 3 behaves as a full triangle
    push_triangle();
    send(0, 0, 2, 0, 0, 2, 2'd3, 1'b0);
    wait_done("mode3", 0);

    // reset in the middle of DRAW
    push_triangle();
    send(0, 0, 2, 0, 0, 2, 2'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b0;
    #1;
    check("mid_rst_pix_valid", 32'(bus.pix_valid), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_done", 32'(bus.done), 0);
    check("mid_rst_clip", 32'(bus.clip_count), 0);
    check("mid_rst_tri_ready", 32'(bus.tri_ready), 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    #1;
    check("post_rst_tri_ready", 32'(bus.tri_ready), 1);
    line_test("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
